// File: rtl/p_result_rx.sv
// Serial result receiver: rebuilds MSB-first words from the accelerator's P_out
// stream, buffers them in a small FIFO for the host and checks each frame at finish.
module p_result_rx #(
  parameter int WORD_W    = 18,
  parameter int NUM_WORDS = 16,
  parameter int DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              p_in,
  input  logic              p_in_valid,
  input  logic              finish,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [3:0]        word_idx,
  output logic              frame_done,
  output logic              frame_err,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(WORD_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);
  localparam logic [4:0]    EXP_CNT  = 5'(NUM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

  typedef struct packed {
    logic [3:0]        idx;
    logic [WORD_W-1:0] data;
  } entry_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BW-1:0]     r_bit_cnt;
  logic [4:0]        r_word_cnt;
  logic [WORD_W-2:0] r_shreg;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  entry_t            r_mem [DEPTH];
  logic              r_frame_err;
  logic              r_overflow;

  logic w_restart, w_clear_fifo, w_sample, w_check;
  logic w_last, w_full, w_empty, w_pop, w_push, w_drop;

  // NOTE: state and all registers use non-blocking assignments so every flop
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // an unassigned path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_in) w_state_nxt = S_RECV;
      S_RECV:  if (start_in) w_state_nxt = S_RECV;
               else if (finish) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_restart    = 1'b0;
    w_clear_fifo = 1'b0;
    w_sample     = 1'b0;
    w_check      = 1'b0;
    frame_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_restart    = start_in;
        w_clear_fifo = start_in;
      end
      S_RECV: begin
        w_restart = start_in;
        w_sample  = !start_in && p_in_valid;
      end
      S_CHECK: begin
        w_check    = 1'b1;
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_last  = w_sample && (r_bit_cnt == LAST_BIT);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && word_ready;
  // A pop in the same edge frees the slot, so a full FIFO still accepts the word.
  assign w_push  = w_last && (!w_full || w_pop);
  assign w_drop  = w_last && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_shreg    <= '0;
    end else if (w_restart) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (w_sample) begin
      r_shreg   <= {r_shreg[WORD_W-3:0], p_in};
      r_bit_cnt <= w_last ? '0 : r_bit_cnt + BW'(1);
      if (w_last && r_word_cnt != '1) r_word_cnt <= r_word_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_clear_fifo) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // NOTE: the storage array is not reset; validity comes only from the pointers,
  // and the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= '{idx: r_word_cnt[3:0], data: {r_shreg, p_in}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_restart) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_check && (r_bit_cnt != '0 || r_word_cnt != EXP_CNT)) r_frame_err <= 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign word_valid = !w_empty;
  assign word_out   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]].data;
  assign word_idx   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]].idx;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule
